// File: rtl/pipe_chain_if.sv
// Valid/ready handshake bundle for both ends of an elastic pipeline chain.
// The chain is the slave; the upstream producer / downstream consumer side is the master.
interface pipe_chain_if #(
    parameter int unsigned N = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/pipe_chain.sv
// Elastic chain of DEPTH register stages with per-stage valid, bubble collapsing,
// synchronous flush and an occupancy count derived from the valid bits.
module pipe_chain #(
    parameter  int unsigned N     = 32,
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    pipe_chain_if.slave   bus,
    output logic [CW-1:0] occupancy
);
    logic [DEPTH-1:0] r_valid;
    logic [N-1:0]     r_data [DEPTH];

    logic [DEPTH-1:0] w_accept;
    logic [DEPTH-1:0] w_fill;
    logic             w_out_valid;
    logic             w_out_adv;
    logic             w_in_ready;
    logic             w_in_xfer;
    logic [CW-1:0]    w_occ;

    assign w_out_valid = r_valid[DEPTH-1] & ~flush;
    assign w_out_adv   = w_out_valid & bus.out_ready;

    // A stage can take new contents if it or any stage downstream of it is empty,
    // or the last stage is draining this cycle.
    always_comb begin
        w_accept = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_accept[i] = w_out_adv;
            for (int j = i; j < DEPTH; j++) begin
                if (!r_valid[j]) begin
                    w_accept[i] = 1'b1;
                end
            end
        end
    end

    assign w_in_ready = w_accept[0] & ~flush;
    assign w_in_xfer  = bus.in_valid & w_in_ready;

    // Stage i receives a word when its upstream neighbour holds one and it accepts.
    always_comb begin
        w_fill    = '0;
        w_fill[0] = w_in_xfer;
        for (int i = 1; i < DEPTH; i++) begin
            w_fill[i] = r_valid[i-1] & w_accept[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
            end
        end else if (flush) begin
            r_valid <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_accept[i]) begin
                    r_valid[i] <= w_fill[i];
                end
            end
            // Data only moves on a real transfer so idle input data never enters a stage.
            if (w_fill[0]) begin
                r_data[0] <= bus.in_data;
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (w_fill[i]) begin
                    r_data[i] <= r_data[i-1];
                end
            end
        end
    end

    always_comb begin
        w_occ = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_occ = w_occ + CW'(r_valid[i]);
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = r_data[DEPTH-1];
    assign occupancy     = w_occ;
endmodule

// File: tb/tb_pipe_chain.sv
// Self-checking bench for pipe_chain at DEPTH 1, 2 and 3 against a per-word position model.
module tb_pipe_chain;
    localparam int unsigned N = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic flush = 1'b0;
    always #5 clk = ~clk;

    pipe_chain_if #(.N(N)) if1 ();
    pipe_chain_if #(.N(N)) if2 ();
    pipe_chain_if #(.N(N)) if3 ();
    logic [0:0] occ1;
    logic [1:0] occ2;
    logic [1:0] occ3;

    pipe_chain #(.N(N), .DEPTH(1)) u_d1 (.clk(clk), .reset(reset), .flush(flush), .bus(if1), .occupancy(occ1));
    pipe_chain #(.N(N), .DEPTH(2)) u_d2 (.clk(clk), .reset(reset), .flush(flush), .bus(if2), .occupancy(occ2));
    pipe_chain #(.N(N), .DEPTH(3)) u_d3 (.clk(clk), .reset(reset), .flush(flush), .bus(if3), .occupancy(occ3));

    int checks   = 0;
    int failures = 0;
    int sel      = 2;
    int m_depth  = 2;

    // Model: queue of resident words (oldest first) with their stage position.
    logic [N-1:0] m_data [$];
    int           m_pos  [$];
    int           mv_np  [8];
    bit           mv_pop;
    bit           mv_irdy;
    bit           pending = 1'b0;
    bit           cur_iv, cur_ordy, cur_fl, cur_rs;
    logic [N-1:0] cur_id;

    logic         s_ov, s_ir, e_ov, e_ir;
    logic [N-1:0] s_od, s_odm, e_od;
    logic [3:0]   s_occ, e_occ;
    logic [N-1:0] got [$];

    always_comb begin
        case (sel)
            1: begin s_ov = if1.out_valid; s_od = if1.out_data; s_ir = if1.in_ready; s_occ = 4'(occ1); end
            3: begin s_ov = if3.out_valid; s_od = if3.out_data; s_ir = if3.in_ready; s_occ = 4'(occ3); end
            default: begin s_ov = if2.out_valid; s_od = if2.out_data; s_ir = if2.in_ready; s_occ = 4'(occ2); end
        endcase
    end

    // Each word steps one stage forward per cycle unless the word ahead blocks it.
    task automatic model_plan();
        int limit;
        mv_pop  = 1'b0;
        mv_irdy = 1'b0;
        limit   = m_depth - 1;
        if (cur_fl) return;
        for (int k = 0; k < m_data.size(); k++) begin
            if (k == 0 && m_pos[0] == m_depth - 1 && cur_ordy) begin
                mv_pop   = 1'b1;
                mv_np[0] = m_depth;
            end else begin
                mv_np[k] = (m_pos[k] + 1 > limit) ? limit : m_pos[k] + 1;
                limit    = mv_np[k] - 1;
            end
        end
        mv_irdy = (m_data.size() == 0) || (mv_np[m_data.size() - 1] > 0);
    endtask

    task automatic model_commit();
        if (!cur_rs || cur_fl) begin
            m_data.delete();
            m_pos.delete();
        end else begin
            for (int k = 0; k < m_pos.size(); k++) m_pos[k] = mv_np[k];
            if (mv_pop) begin
                void'(m_data.pop_front());
                void'(m_pos.pop_front());
            end
            if (cur_iv && mv_irdy) begin
                m_data.push_back(cur_id);
                m_pos.push_back(0);
            end
        end
    endtask

    task automatic begin_test(input int s, input int d);
        pending = 1'b0;
        m_data.delete();
        m_pos.delete();
        got.delete();
        sel     = s;
        m_depth = d;
    endtask

    // One cycle: commit last edge into the model, drive inputs, sample and predict.
    task automatic drive(input bit iv, input logic [N-1:0] id, input bit ordy, input bit fl, input bit rs);
        @(negedge clk);
        if (pending) model_commit();
        if1.in_valid = (sel == 1) && iv;  if1.in_data = id;  if1.out_ready = (sel == 1) && ordy;
        if2.in_valid = (sel == 2) && iv;  if2.in_data = id;  if2.out_ready = (sel == 2) && ordy;
        if3.in_valid = (sel == 3) && iv;  if3.in_data = id;  if3.out_ready = (sel == 3) && ordy;
        flush    = fl;
        reset    = rs;
        cur_iv   = iv;
        cur_id   = id;
        cur_ordy = ordy;
        cur_fl   = fl;
        cur_rs   = rs;
        pending  = 1'b1;
        #1;
        model_plan();
        e_ov  = (m_data.size() > 0) && (m_pos[0] == m_depth - 1) && !fl;
        e_od  = e_ov ? m_data[0] : '0;
        e_ir  = mv_irdy;
        e_occ = 4'(m_data.size());
        s_odm = e_ov ? s_od : '0;
        if (rs && !fl && s_ov && ordy) got.push_back(s_od);
    endtask

    task automatic test_reset();
        for (int d = 1; d <= 3; d++) begin
            begin_test(d, d);
            drive(1'b0, 'x, 1'b0, 1'b0, 1'b0);
            drive(1'b0, 'x, 1'b0, 1'b0, 1'b1);
            checks++; if (s_ov !== 1'b0) begin failures++; $display("FAIL reset_out_valid d%0d got %b exp 0", d, s_ov); end
            checks++; if (s_od !== 4'd0) begin failures++; $display("FAIL reset_out_data d%0d got %h exp 0", d, s_od); end
            checks++; if (s_ir !== 1'b1) begin failures++; $display("FAIL reset_in_ready d%0d got %b exp 1", d, s_ir); end
            checks++; if (s_occ !== 4'd0) begin failures++; $display("FAIL reset_occupancy d%0d got %0d exp 0", d, s_occ); end
        end
    endtask

    task automatic test_stream();
        int first_ov = -1;
        begin_test(2, 2);
        drive(1'b0, 'x, 1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 10; c++) begin
            drive(c < 6, 4'(c + 1), 1'b1, 1'b0, 1'b1);
            if (s_ov === 1'b1 && first_ov < 0) first_ov = c;
            checks++;
            if ({s_ov, s_odm, s_ir, s_occ} !== {e_ov, e_od, e_ir, e_occ}) begin
                failures++;
                $display("FAIL stream c%0d ov,od,ir,occ got %b,%h,%b,%0d exp %b,%h,%b,%0d", c, s_ov, s_odm, s_ir, s_occ, e_ov, e_od, e_ir, e_occ);
            end
        end
        checks++; if (first_ov != 2) begin failures++; $display("FAIL stream_latency got %0d exp 2", first_ov); end
        checks++; if (got.size() != 6) begin failures++; $display("FAIL stream_count got %0d exp 6", got.size()); end
        for (int k = 0; k < got.size() && k < 6; k++) begin
            checks++; if (got[k] !== 4'(k + 1)) begin failures++; $display("FAIL stream_word%0d got %h exp %h", k, got[k], 4'(k + 1)); end
        end
    endtask

    task automatic test_backpressure();
        int w = 0;
        begin_test(2, 2);
        drive(1'b0, 'x, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 14; c++) begin
            drive(w < 3, 4'(w + 1), c >= 4, 1'b0, 1'b1);
            if (w < 3 && e_ir) w++;
            checks++;
            if ({s_ov, s_odm, s_ir, s_occ} !== {e_ov, e_od, e_ir, e_occ}) begin
                failures++;
                $display("FAIL backpressure c%0d ov,od,ir,occ got %b,%h,%b,%0d exp %b,%h,%b,%0d", c, s_ov, s_odm, s_ir, s_occ, e_ov, e_od, e_ir, e_occ);
            end
            if (c == 3) begin
                checks++;
                if ({s_od, s_ir, s_occ} !== {4'd1, 1'b0, 4'd2}) begin
                    failures++; $display("FAIL backpressure_full od,ir,occ got %h,%b,%0d exp 1,0,2", s_od, s_ir, s_occ);
                end
            end
        end
        checks++; if (got.size() != 3) begin failures++; $display("FAIL backpressure_count got %0d exp 3", got.size()); end
        for (int k = 0; k < got.size() && k < 3; k++) begin
            checks++; if (got[k] !== 4'(k + 1)) begin failures++; $display("FAIL backpressure_word%0d got %h exp %h", k, got[k], 4'(k + 1)); end
        end
    endtask

    task automatic test_bubble();
        logic [N-1:0] words [6];
        bit           vals  [6];
        words = '{4'hA, 4'h0, 4'h0, 4'hB, 4'hC, 4'hD};
        vals  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        begin_test(3, 3);
        drive(1'b0, 'x, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 6; c++) begin
            drive(vals[c], vals[c] ? words[c] : 'x, 1'b0, 1'b0, 1'b1);
            checks++;
            if ({s_ov, s_odm, s_ir, s_occ} !== {e_ov, e_od, e_ir, e_occ}) begin
                failures++;
                $display("FAIL bubble c%0d ov,od,ir,occ got %b,%h,%b,%0d exp %b,%h,%b,%0d", c, s_ov, s_odm, s_ir, s_occ, e_ov, e_od, e_ir, e_occ);
            end
        end
        checks++;
        if ({s_ov, s_od, s_ir, s_occ} !== {1'b1, 4'hA, 1'b0, 4'd3}) begin
            failures++; $display("FAIL bubble_full ov,od,ir,occ got %b,%h,%b,%0d exp 1,a,0,3", s_ov, s_od, s_ir, s_occ);
        end
    endtask

    task automatic test_flush();
        int first_ov = -1;
        begin_test(3, 3);
        drive(1'b0, 'x, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 10; c++) begin
            drive(c <= 4, 4'(c + 1), c >= 4, c == 3, 1'b1);
            if (c >= 4 && s_ov === 1'b1 && first_ov < 0) first_ov = c;
            checks++;
            if ({s_ov, s_odm, s_ir, s_occ} !== {e_ov, e_od, e_ir, e_occ}) begin
                failures++;
                $display("FAIL flush c%0d ov,od,ir,occ got %b,%h,%b,%0d exp %b,%h,%b,%0d", c, s_ov, s_odm, s_ir, s_occ, e_ov, e_od, e_ir, e_occ);
            end
            if (c == 3) begin
                checks++; if ({s_ov, s_ir} !== 2'b00) begin failures++; $display("FAIL flush_gate ov,ir got %b,%b exp 0,0", s_ov, s_ir); end
            end
            if (c == 4) begin
                checks++; if ({s_ov, s_occ} !== {1'b0, 4'd0}) begin failures++; $display("FAIL flush_clear ov,occ got %b,%0d exp 0,0", s_ov, s_occ); end
            end
        end
        checks++; if (first_ov != 7) begin failures++; $display("FAIL flush_latency got %0d exp 7", first_ov); end
        checks++; if (got.size() != 1 || got[0] !== 4'd5) begin failures++; $display("FAIL flush_drain got %0d words exp one word 5", got.size()); end
    endtask

    task automatic test_reset_midstream();
        int w = 0;
        logic [N-1:0] exp_words [3];
        exp_words = '{4'd1, 4'd5, 4'd6};
        begin_test(2, 2);
        drive(1'b0, 'x, 1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 10; c++) begin
            drive(w < 6, 4'(w + 1), 1'b1, 1'b0, c != 3);
            if (w < 6 && e_ir) w++;
            checks++;
            if ({s_ov, s_odm, s_ir, s_occ} !== {e_ov, e_od, e_ir, e_occ}) begin
                failures++;
                $display("FAIL midreset c%0d ov,od,ir,occ got %b,%h,%b,%0d exp %b,%h,%b,%0d", c, s_ov, s_odm, s_ir, s_occ, e_ov, e_od, e_ir, e_occ);
            end
            if (c == 4) begin
                checks++;
                if ({s_ov, s_od, s_ir, s_occ} !== {1'b0, 4'd0, 1'b1, 4'd0}) begin
                    failures++; $display("FAIL midreset_state ov,od,ir,occ got %b,%h,%b,%0d exp 0,0,1,0", s_ov, s_od, s_ir, s_occ);
                end
            end
        end
        checks++; if (got.size() != 3) begin failures++; $display("FAIL midreset_count got %0d exp 3", got.size()); end
        for (int k = 0; k < got.size() && k < 3; k++) begin
            checks++; if (got[k] !== exp_words[k]) begin failures++; $display("FAIL midreset_word%0d got %h exp %h", k, got[k], exp_words[k]); end
        end
    endtask

    task automatic test_depth1_toggle();
        int w = 0;
        begin_test(1, 1);
        drive(1'b0, 'x, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 16; c++) begin
            drive(1'b1, 4'(w), (c % 2) == 0, 1'b0, 1'b1);
            if (e_ir) w++;
            checks++;
            if ({s_ov, s_odm, s_ir, s_occ} !== {e_ov, e_od, e_ir, e_occ}) begin
                failures++;
                $display("FAIL depth1 c%0d ov,od,ir,occ got %b,%h,%b,%0d exp %b,%h,%b,%0d", c, s_ov, s_odm, s_ir, s_occ, e_ov, e_od, e_ir, e_occ);
            end
        end
        checks++; if (got.size() != 7) begin failures++; $display("FAIL depth1_count got %0d exp 7", got.size()); end
        for (int k = 0; k < got.size(); k++) begin
            checks++; if (got[k] !== 4'(k)) begin failures++; $display("FAIL depth1_word%0d got %h exp %h", k, got[k], 4'(k)); end
        end
    endtask

    task automatic test_random();
        bit iv, ordy, fl;
        logic [N-1:0] id;
        for (int d = 1; d <= 3; d++) begin
            begin_test(d, d);
            drive(1'b0, 'x, 1'b0, 1'b0, 1'b0);
            for (int c = 0; c < 120; c++) begin
                iv   = 1'($urandom_range(0, 1));
                ordy = ($urandom_range(0, 9) < 6);
                fl   = ($urandom_range(0, 19) == 0);
                id   = iv ? 4'($urandom) : 'x;
                drive(iv, id, ordy, fl, 1'b1);
                checks++;
                if ({s_ov, s_odm, s_ir, s_occ} !== {e_ov, e_od, e_ir, e_occ}) begin
                    failures++;
                    $display("FAIL random d%0d c%0d ov,od,ir,occ got %b,%h,%b,%0d exp %b,%h,%b,%0d", d, c, s_ov, s_odm, s_ir, s_occ, e_ov, e_od, e_ir, e_occ);
                end
            end
        end
    endtask

    initial begin
        if1.in_valid = 1'b0; if1.in_data = '0; if1.out_ready = 1'b0;
        if2.in_valid = 1'b0; if2.in_data = '0; if2.out_ready = 1'b0;
        if3.in_valid = 1'b0; if3.in_data = '0; if3.out_ready = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_bubble();
        test_flush();
        test_reset_midstream();
        test_depth1_toggle();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/pipe_chain.md
Name: pipe_chain

Overview:
Parametrised chain of pipeline registers with per-stage valid bits and valid/ready flow control. It generalises the plain write-enabled flipflop stage into an elastic pipeline of configurable width and depth, adding backpressure, bubble collapsing, flush and an occupancy count. It is the building block for inter-stage buffering between CPU pipeline stages and toward memory ports.

Parameters:
N, 32, data width in bits (>=1)
DEPTH, 2, number of register stages (>=1)
CW, $clog2(DEPTH+1), width of occupancy output (derived; not overridden)

Ports:
clk  input  1  clock; all state changes on rising edge
reset  input  1  synchronous, active-low reset (asserted when 0, sampled on rising clk)
flush  input  1  synchronous clear of all stage contents
in_valid  input  1  upstream presents in_data
in_ready  output  1  chain accepts in_data this cycle
in_data  input  N  upstream payload
out_valid  output  1  last stage holds valid data
out_ready  input  1  downstream accepts out_data this cycle
out_data  output  N  payload of last stage
occupancy  output  CW  number of valid stages (0..DEPTH)

Behaviour:
- Stage i (0..DEPTH-1) holds valid[i], data[i]; stage 0 is fed by input, stage DEPTH-1 drives out_*.
- Reset (reset==0 at edge): all valid[i]=0, all data[i]=0. Thus out_valid=0, out_data=0, occupancy=0, in_ready=1 (after reset releases). Reset dominates flush and all handshakes.
- Advance terms (combinational): adv[DEPTH-1] = out_valid & out_ready; adv[i] = valid[i] & (!valid[i+1] | adv[i+1]) for i<DEPTH-1.
- Stage i accepts when !valid[i] | adv[i] (bubble collapsing: an empty stage fills even if stages downstream are stalled).
- in_ready = (!valid[0] | adv[0]) & !flush. Input transfer = in_valid & in_ready.
- On edge: stage i loads data[i-1] (or in_data for i=0) and valid from the upstream transfer when it accepts; otherwise it holds data and valid unchanged.
- Data never changes while valid[i] & !adv[i]; out_data stable while out_valid & !out_ready.
- Latency: a word accepted at edge t with empty chain and out_ready=1 appears on out_* after edge t+DEPTH-1 (DEPTH cycles input-to-output register count). Throughput: one word per cycle when out_ready stays 1.
- Full: all valid=1 and out_ready=0 -> in_ready=0. Full with out_ready=1 -> in_ready=1; simultaneous in/out transfer keeps occupancy constant.
- Flush=1 (reset deasserted): out_valid forced 0 and in_ready forced 0 combinationally (no transfer in that cycle); at edge all valid[i] cleared, data registers hold. Occupancy 0 next cycle.
- occupancy = popcount(valid), registered-state derived, updates one cycle after edge effects.
- Combinational path out_ready -> in_ready is permitted (no skid buffer).
- DEPTH=1: single register; in_ready = !valid[0] | out_ready.
- X on in_data while in_valid=0 must not propagate to valid bits.

Test Plan:
- DEPTH=2, N=4, out_ready=1, in_valid=1 with in_data 1,2,3,4,5,6 on successive cycles -> out_data 1..6 on consecutive cycles, first one 2 edges after first accept; occupancy steady at 2.
- DEPTH=2, out_ready=0, push 1,2,3 -> accepts 1 and 2, in_ready=0 while 3 offered, out_data held at 1, occupancy=2; raise out_ready -> 1,2,3 drain in order, no loss/duplication.
- DEPTH=3, push single word A, out_ready=0, then push B, C -> bubble collapse: A reaches last stage, B and C fill behind, occupancy 3, in_ready=0.
- DEPTH=3 with 3 words resident, assert flush for one cycle while in_valid=1 -> no transfer that cycle, occupancy=0 next cycle, out_valid=0; next word pushed exits 3 edges later.
- Streaming 1..6 with reset pulsed low for one edge mid-stream -> next cycle out_valid=0, out_data=0, occupancy=0, in_ready=1; post-reset word exits normally.
- DEPTH=1, out_ready toggling 1/0 each cycle, in_valid=1 with incrementing data -> each value output exactly once, held stable while out_ready=0.
